// File: rtl/insn_prefetch.sv
// rtl/insn_prefetch.sv - in-order instruction prefetch queue between the core and instruction memory
module insn_prefetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] fetch_addr,
  output logic [31:0]   insn,
  output logic          insn_valid,
  input  logic          insn_ready,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [AW-1:0] head_addr, next_req_addr;
  logic          run;
  logic [CW:0]   occupancy;
  logic          redirect, pop, push, drop, issue;

  assign redirect  = (fetch_addr != head_addr);
  assign occupancy = {1'b0, count} + {1'b0, outstanding} + {1'b0, discard};

  // run holds requests off until the first edge after reset release
  assign mem_req    = run && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign mem_addr   = next_req_addr;
  assign insn_valid = (count != '0) && !redirect;
  assign insn       = insn_valid ? q_data[rd_ptr] : 32'h0;

  assign pop   = insn_valid && insn_ready;
  assign drop  = mem_rvalid && (discard != '0);
  assign push  = mem_rvalid && (discard == '0);
  assign issue = mem_req && mem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      outstanding   <= '0;
      discard       <= '0;
      head_addr     <= '0;
      next_req_addr <= '0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        // every in-flight response, less the one landing now, becomes garbage
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        count         <= '0;
        outstanding   <= '0;
        discard       <= discard + outstanding - CW'(mem_rvalid);
        head_addr     <= fetch_addr;
        next_req_addr <= fetch_addr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr    <= rd_ptr + PW'(1);
          head_addr <= head_addr + AW'(1);
        end
        if (issue) next_req_addr <= next_req_addr + AW'(1);
        count       <= count + CW'(push) - CW'(pop);
        outstanding <= outstanding + CW'(issue) - CW'(push);
        discard     <= discard - CW'(drop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !redirect) q_data[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_insn_prefetch.sv
// tb/tb_insn_prefetch.sv - scoreboard bench for insn_prefetch with a latency/grant-configurable memory model
module tb_insn_prefetch;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [31:0]   insn;
  logic          insn_valid;
  logic          insn_ready = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;

  insn_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_addr(fetch_addr),
    .insn(insn), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return 32'(a) + 32'h100;
  endfunction

  // memory model: in-order responses, fixed latency, selectable grant pattern
  typedef struct { logic [AW-1:0] addr; int due; } req_t;
  req_t mq[$];
  int lat = 1;
  int gnt_mode = 0;
  int cyc = 0;
  int grants = 0;
  logic last_hs = 1'b0;
  logic prev_wait = 1'b0;
  logic [AW-1:0] prev_maddr = '0, prev_fetch = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      mq.delete();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      prev_wait = 1'b0;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata = word_at(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
      end
      case (gnt_mode)
        0: mem_gnt = 1'b1;
        1: mem_gnt = cyc[0];
        default: mem_gnt = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_wait && fetch_addr == prev_fetch && !last_hs) begin
        check("req_hold", mem_req, 1);
        check("addr_hold", mem_addr, prev_maddr);
      end
      if (mem_req && mem_gnt) begin
        mq.push_back('{mem_addr, cyc + lat});
        grants++;
        check("in_flight_le_depth", mq.size() <= DEPTH, 1);
      end
      prev_wait = mem_req && !mem_gnt;
      prev_maddr = mem_addr;
      prev_fetch = fetch_addr;
    end
  end

  // scoreboard monitor
  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } exp_t;
  exp_t sb[$];

  initial forever begin
    @(negedge clk);
    #2;
    last_hs = 1'b0;
    if (rst_n) begin
      if (!insn_valid) check("insn_zero_when_invalid", insn, 0);
      if (insn_valid && insn_ready) begin
        last_hs = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_consume: got %0h at %0h expected none", insn, fetch_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("consume_addr", fetch_addr, e.addr);
          check("consume_insn", insn, e.data);
        end
      end
    end
  end

  // core driver: the core's next pc is the last consumed address + 1 unless it jumps
  logic [AW-1:0] exp_head = '0;
  int stall_cnt = 0;

  task automatic fetch(input logic [AW-1:0] a, input int n, input int rdy_pct);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] pc;
      int budget;
      bit done;
      bit first;
      pc = a + AW'(i);
      budget = 0;
      done = 0;
      first = 1;
      @(negedge clk);
      fetch_addr = pc;
      sb.push_back('{pc, word_at(pc)});
      while (!done) begin
        insn_ready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        if (first && pc != exp_head) check("redirect_cycle_invalid", insn_valid, 0);
        first = 0;
        if (insn_valid && insn_ready) begin
          done = 1;
        end else begin
          budget++;
          stall_cnt++;
          if (budget > 200) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: no insn at %0h after %0d cycles, expected one", pc, budget);
            finish_sim();
          end
          @(negedge clk);
        end
      end
      exp_head = pc + AW'(1);
    end
  endtask

  task automatic abandon(input logic [AW-1:0] a, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      fetch_addr = a;
      insn_ready = 1'b0;
    end
    exp_head = a;
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    finish_sim();
  end

  initial begin
    rst_n = 1'b0;
    #3;
    check("rst_insn_valid", insn_valid, 0);
    check("rst_insn", insn, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;

    // core stalled with fast memory: queue fills to exactly DEPTH
    lat = 1;
    gnt_mode = 0;
    grants = 0;
    repeat (12) @(negedge clk);
    #2;
    check("full_grants", grants, DEPTH);
    check("full_mem_req", mem_req, 0);
    check("full_insn_valid", insn_valid, 1);
    check("full_insn", insn, 32'h100);
    fetch(0, 4, 100);
    stall_cnt = 0;
    fetch(4, 20, 100);
    check("steady_stalls", stall_cnt, 0);

    // redirect while requests are in flight
    lat = 5;
    fetch(24, 2, 100);
    abandon(26, 1);
    fetch(32'h40, 4, 100);

    // slow memory with alternating grant
    gnt_mode = 1;
    fetch(32'h200, 30, 70);

    // wrap-around at the top of the address space
    lat = 1;
    gnt_mode = 0;
    fetch(32'hFFFF_FFF0, 4, 100);
    stall_cnt = 0;
    fetch(32'hFFFF_FFF4, 20, 100);
    check("wrap_stalls", stall_cnt, 0);

    // randomized segments
    for (int k = 0; k < 12; k++) begin
      lat = $urandom_range(1, 4);
      gnt_mode = 2;
      if ($urandom_range(0, 2) == 0) abandon(AW'($urandom_range(0, 4095)), $urandom_range(1, 3));
      fetch(AW'($urandom_range(0, 4095)), $urandom_range(3, 10), 60);
    end

    // asynchronous reset in the middle of a slow stream
    lat = 5;
    gnt_mode = 0;
    fetch(32'h300, 6, 100);
    @(negedge clk);
    fetch_addr = 32'h306;
    insn_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_insn_valid", insn_valid, 0);
    check("midrst_insn", insn, 0);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_mem_addr", mem_addr, 0);
    sb.delete();
    fetch_addr = '0;
    exp_head = '0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    fetch(0, 8, 100);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    finish_sim();
  end

endmodule

// File: doc/insn_prefetch.md
Name: insn_prefetch

Overview:
- Instruction-side stage directly upstream of the core.
- Accepts the core's word-granular instruction address and returns the 32-bit instruction word with a valid/ready handshake.
- Hides multi-cycle instruction-memory latency with a small in-order prefetch queue. It fetches sequential words ahead of the core and flushes on any non-sequential address (branch to r31).

Parameters:
- DEPTH, 4: prefetch queue entries; power of two, minimum 2.
- AW, 32: word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_addr  in  AW  word address the core wants next (core pc).
- insn  out  32  instruction word for fetch_addr; 0 when insn_valid=0.
- insn_valid  out  1  insn is the word at fetch_addr.
- insn_ready  in  1  core consumes insn this cycle.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  AW  word address of the request.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data returned; responses arrive in request order.
- mem_rdata  in  32  returned word.

Behaviour:
- Reset (async, rst_n=0):
  - Queue empty; outstanding=0; discard=0.
  - head_addr=0; next_req_addr=0.
  - mem_req=0, mem_addr=0, insn_valid=0, insn=0.
- First cycle after reset release: prefetch starts at address 0.
- State: head_addr (address of the oldest queue entry) and next_req_addr (address of the next request). Counters: count (entries held), outstanding (granted, not returned), discard (responses to drop).
- Hit:
  - insn_valid = (count>0) and (fetch_addr==head_addr); insn = head data.
  - Combinational from fetch_addr, so a hit has zero added latency.
- Consume: on insn_valid & insn_ready, pop the head and increment head_addr. Sequential core flow therefore presents the next word the following cycle if it is queued.
- Redirect:
  - Trigger: fetch_addr != head_addr. Evaluated every cycle, including when the queue is empty and requests are in flight.
  - Same cycle: insn_valid=0.
  - Next edge: queue cleared; head_addr and next_req_addr set to fetch_addr; discard increased by outstanding minus any response returning this cycle; outstanding set to 0.
  - No request is issued in the redirect cycle.
- Request issue:
  - mem_req=1 when no redirect and count + outstanding + discard < DEPTH; mem_addr=next_req_addr.
  - mem_req/mem_addr stay stable until mem_gnt.
  - On mem_req & mem_gnt: next_req_addr++, outstanding++.
- Response:
  - On mem_rvalid with discard>0: drop the word, discard--.
  - Otherwise push mem_rdata to the tail, outstanding--.
  - A response with outstanding=0 and discard=0 is a protocol error; the verification bench asserts against it.
- Simultaneous push and pop in one cycle: count unchanged, both take effect.
- Full: the issue rule guarantees a push never overflows; no backpressure to memory is required.
- Wrap-around: address increments wrap modulo 2^AW; queue pointers wrap modulo DEPTH.
- Reset mid-operation: all in-flight responses are forgotten. The memory side must also be reset with the same rst_n.
- Arithmetic: counters are clog2(DEPTH)+1 bits wide.
- Core integration: the core advances pc only when insn_valid & insn_ready. Its posedge latch uses insn only while insn_valid=1.

Test Plan:
- Reset then 1-cycle-latency memory, always granting, with word n = n+0x100; core ready every cycle -> insn 0x100,0x101,0x102… at fetch_addr 0,1,2…, valid every cycle after the initial fill; mem_req never exceeds DEPTH in flight.
- insn_ready=0 for 10 cycles with fast memory -> exactly DEPTH=4 requests issued (addrs 0–3); mem_req=0 while full; no words lost when ready returns.
- Redirect: at fetch_addr=2 with 2 outstanding, the core switches to 0x40 -> insn_valid=0 that cycle; the next 2 responses are dropped; the first valid insn is word 0x40 (0x140).
- Memory latency 5 cycles, mem_gnt toggling every other cycle -> in-order delivery preserved; mem_addr stable while mem_req=1 and mem_gnt=0.
- rst_n asserted mid-stream with 3 outstanding -> all outputs 0 immediately (async); after release, fetching restarts at address 0 with no stale words delivered.
- Simultaneous push and pop for 20 cycles at steady state -> count constant and outputs correct; fetch_addr near 2^AW-1 wraps to 0 without a redirect.
